// File: rtl/keypad_digit_entry.sv
// Debounced 4x4 keypad to BCD digit-entry buffer; define KEYPAD_ROLL_EN to roll a full buffer.
// Key change to event pulse: DEBOUNCE_CYCLES+2 edges; no backpressure, events are never stalled.
module keypad_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4,
    parameter int CNT_W           = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  onehot,
    input  logic                         clear,
    output logic [4*DIGITS-1:0]          digits,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         full,
    output logic                         digit_valid,
    output logic                         overflow,
    output logic                         entry_valid,
    output logic [4*DIGITS-1:0]          entry_value,
    output logic [$clog2(DIGITS+1)-1:0]  entry_len,
    output logic [CNT_W-1:0]             press_cnt
);
    localparam int LW = $clog2(DIGITS+1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
    localparam logic [LW-1:0] FULL_CNT = LW'(DIGITS);
    localparam logic [DW-1:0] LAST_CNT = DW'(DEBOUNCE_CYCLES-1);
    localparam logic [DW-1:0] ONE_CNT  = DW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   sample;
    logic [15:0]   key, key_nxt;
    logic [15:0]   stable, stable_nxt, stable_q;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          single_hot;
    logic          restart, settle;
    logic [15:0]   settle_val;

    logic          evt_new, evt_digit, evt_enter, evt_bs, evt_any;
    logic [3:0]    evt_code;

    assign single_hot = (onehot != 16'h0000) && ((onehot & (onehot - 16'h0001)) == 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample   <= '0;
            stable_q <= '0;
        end else begin
            sample   <= single_hot ? onehot : 16'h0000;
            stable_q <= stable;
        end
    end

    // Debounce FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            key    <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            key    <= key_nxt;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // key tracks the value being counted; a release (0) is debounced like any other value
    always_comb begin
        state_nxt  = state;
        key_nxt    = key;
        stable_nxt = stable;
        cnt_nxt    = cnt;
        restart    = 1'b0;
        settle     = 1'b0;
        settle_val = key;
        case (state)
            IDLE: begin
                restart = (sample != 16'h0000);
            end
            ARMED: begin
                if (sample != key) begin
                    restart = 1'b1;
                end else if (cnt >= LAST_CNT) begin
                    settle = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                restart = (sample != stable);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (restart) begin
            key_nxt    = sample;
            settle_val = sample;
            if (DEBOUNCE_CYCLES == 1) begin
                settle = 1'b1;
            end else begin
                state_nxt = ARMED;
                cnt_nxt   = ONE_CNT;
            end
        end
        if (settle) begin
            stable_nxt = settle_val;
            cnt_nxt    = '0;
            state_nxt  = (settle_val == 16'h0000) ? IDLE : HELD;
        end
    end

    // Event decode: fires the cycle after stable takes a new nonzero value
    always_comb begin
        evt_new   = (stable != stable_q) && (stable != 16'h0000);
        evt_digit = 1'b0;
        evt_enter = 1'b0;
        evt_bs    = 1'b0;
        evt_code  = 4'd0;
        if (evt_new) begin
            case (stable)
                16'h0008: begin evt_digit = 1'b1; evt_code = 4'd0; end
                16'h0080: begin evt_digit = 1'b1; evt_code = 4'd1; end
                16'h0040: begin evt_digit = 1'b1; evt_code = 4'd2; end
                16'h0020: begin evt_digit = 1'b1; evt_code = 4'd3; end
                16'h0800: begin evt_digit = 1'b1; evt_code = 4'd4; end
                16'h0400: begin evt_digit = 1'b1; evt_code = 4'd5; end
                16'h0200: begin evt_digit = 1'b1; evt_code = 4'd6; end
                16'h8000: begin evt_digit = 1'b1; evt_code = 4'd7; end
                16'h4000: begin evt_digit = 1'b1; evt_code = 4'd8; end
                16'h2000: begin evt_digit = 1'b1; evt_code = 4'd9; end
                16'h0001: evt_enter = 1'b1;
                16'h0010: evt_bs    = 1'b1;
                default: ;
            endcase
        end
    end

    assign evt_any = evt_digit | evt_enter | evt_bs;
    assign full    = (count == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            count       <= '0;
            digit_valid <= 1'b0;
            overflow    <= 1'b0;
            entry_valid <= 1'b0;
            entry_value <= '0;
            entry_len   <= '0;
            press_cnt   <= '0;
        end else begin
            digit_valid <= 1'b0;
            overflow    <= 1'b0;
            entry_valid <= 1'b0;
            if (evt_any && (press_cnt != {CNT_W{1'b1}})) begin
                press_cnt <= press_cnt + 1'b1;
            end
            // clear wins the edge: the concurrent event is counted but has no other effect
            if (clear) begin
                digits <= '0;
                count  <= '0;
            end else if (evt_digit) begin
                if (count < FULL_CNT) begin
                    digits      <= {digits[4*DIGITS-5:0], evt_code};
                    count       <= count + 1'b1;
                    digit_valid <= 1'b1;
                end else begin
                    overflow    <= 1'b1;
`ifdef KEYPAD_ROLL_EN
                    digits      <= {digits[4*DIGITS-5:0], evt_code};
                    digit_valid <= 1'b1;
`endif
                end
            end else if (evt_bs) begin
                if (count != '0) begin
                    digits <= {4'h0, digits[4*DIGITS-1:4]};
                    count  <= count - 1'b1;
                end
            end else if (evt_enter) begin
                entry_valid <= 1'b1;
                entry_value <= digits;
                entry_len   <= count;
                digits      <= '0;
                count       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: directed table, hand sequences and random stimulus vs a reference model.
module tb_keypad_digit_entry;
    localparam int D  = 4;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int LW = $clog2(N+1);
    localparam logic [15:0] K_ENT = 16'h0001;
    localparam logic [15:0] K_BS  = 16'h0010;
`ifdef KEYPAD_ROLL_EN
    localparam logic [15:0] FULL_VAL = 16'h2345;
    localparam int          ROLL_DV  = 1;
`else
    localparam logic [15:0] FULL_VAL = 16'h1234;
    localparam int          ROLL_DV  = 0;
`endif

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic [15:0]    onehot = '0;
    logic           clear  = 1'b0;
    logic [4*N-1:0] digits, entry_value;
    logic [LW-1:0]  count, entry_len;
    logic           full, digit_valid, overflow, entry_valid;
    logic [PW-1:0]  press_cnt;

    keypad_digit_entry #(.DEBOUNCE_CYCLES(D), .DIGITS(N), .CNT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .onehot(onehot), .clear(clear),
        .digits(digits), .count(count), .full(full),
        .digit_valid(digit_valid), .overflow(overflow),
        .entry_valid(entry_valid), .entry_value(entry_value), .entry_len(entry_len),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_dv = 0, n_ov = 0, n_ev = 0;
    int b_dv, b_ov, b_ev;
    int hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference model: a key is accepted once the last D samples agree; buffer is a digit queue
    logic [15:0]    hist[$];
    int             dq[$];
    logic [15:0]    m_stable = '0, m_stable_q = '0;
    int             m_press = 0, m_elen = 0, m_code;
    logic           m_dv = 1'b0, m_ov = 1'b0, m_ev = 1'b0;
    logic [4*N-1:0] m_eval = '0;
    bit             m_acc, m_same;

    function automatic logic [15:0] cand_of(input logic [15:0] x);
        return ($countones(x) == 1) ? x : 16'h0000;
    endfunction

    function automatic int code_of(input logic [15:0] k);
        int r;
        r = -1;
        case (k)
            16'h0008: r = 0;  16'h0080: r = 1;  16'h0040: r = 2;  16'h0020: r = 3;
            16'h0800: r = 4;  16'h0400: r = 5;  16'h0200: r = 6;  16'h8000: r = 7;
            16'h4000: r = 8;  16'h2000: r = 9;
            default:  r = -1;
        endcase
        return r;
    endfunction

    function automatic logic [4*N-1:0] pack_q();
        logic [4*N-1:0] r;
        r = '0;
        for (int i = 0; i < dq.size(); i++) r[4*i +: 4] = 4'(dq[dq.size()-1-i]);
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            hist.delete(); dq.delete();
            m_stable = '0; m_stable_q = '0; m_press = 0;
            m_dv = 0; m_ov = 0; m_ev = 0; m_eval = '0; m_elen = 0;
        end else begin
            m_dv = 0; m_ov = 0; m_ev = 0;
            if (m_stable != m_stable_q && m_stable != 16'h0000) begin
                m_code = code_of(m_stable);
                m_acc  = (m_code >= 0) || (m_stable == K_ENT) || (m_stable == K_BS);
                if (m_acc && m_press < (1 << PW) - 1) m_press++;
                if (m_acc && !clear) begin
                    if (m_code >= 0) begin
                        if (dq.size() < N) begin
                            dq.push_back(m_code); m_dv = 1;
                        end else begin
                            m_ov = 1;
`ifdef KEYPAD_ROLL_EN
                            void'(dq.pop_front()); dq.push_back(m_code); m_dv = 1;
`endif
                        end
                    end else if (m_stable == K_ENT) begin
                        m_ev = 1; m_eval = pack_q(); m_elen = dq.size(); dq.delete();
                    end else if (dq.size() > 0) begin
                        void'(dq.pop_back());
                    end
                end
            end
            if (clear) dq.delete();
            m_stable_q = m_stable;
            if (hist.size() == D) begin
                m_same = 1;
                foreach (hist[i]) if (hist[i] != hist[0]) m_same = 0;
                if (m_same) m_stable = hist[0];
            end
            hist.push_back(cand_of(onehot));
            if (hist.size() > D) void'(hist.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("model_digits", 32'(digits), 32'(pack_q()));
            chk("model_count", 32'(count), dq.size());
            chk("model_full", full, dq.size() == N);
            chk("model_press", 32'(press_cnt), m_press);
            chk("model_pulses", {digit_valid, overflow, entry_valid}, {m_dv, m_ov, m_ev});
            chk("model_entry", {entry_len, entry_value}, {LW'(m_elen), m_eval});
            if (digit_valid) n_dv++;
            if (overflow)    n_ov++;
            if (entry_valid) n_ev++;
        end
    end

    typedef struct {
        logic [15:0] key;
        logic        clr;
        logic [15:0] dig;
        int          cnt;
        int          press;
        int          dv;
        int          ov;
        int          ev;
        logic [15:0] eval;
        int          elen;
    } vec_t;
    vec_t v [20];

    logic [15:0] pool [0:17] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800, 16'h0400,
                                 16'h0200, 16'h8000, 16'h4000, 16'h2000, 16'h0001, 16'h0010,
                                 16'h0002, 16'h0000, 16'h0000, 16'h0081, 16'h00A0, 16'h0010};

    task automatic check_all_zero(input string tag);
        chk({tag, "_digits"}, 32'(digits), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_press"}, 32'(press_cnt), 0);
        chk({tag, "_pulses"}, {digit_valid, overflow, entry_valid}, 0);
        chk({tag, "_entry"}, {entry_len, entry_value}, 0);
    endtask

    initial begin
        v[0]  = '{16'h0080, 1'b0, 16'h0001, 1,  1, 1, 0, 0, 16'h0000, 0};
        v[1]  = '{16'h0040, 1'b0, 16'h0012, 2,  2, 1, 0, 0, 16'h0000, 0};
        v[2]  = '{16'h0020, 1'b0, 16'h0123, 3,  3, 1, 0, 0, 16'h0000, 0};
        v[3]  = '{16'h0800, 1'b0, 16'h1234, 4,  4, 1, 0, 0, 16'h0000, 0};
        v[4]  = '{16'h0400, 1'b0, FULL_VAL, 4,  5, ROLL_DV, 1, 0, 16'h0000, 0};
        v[5]  = '{K_ENT,    1'b0, 16'h0000, 0,  6, 0, 0, 1, FULL_VAL, 4};
        v[6]  = '{16'h0008, 1'b0, 16'h0000, 1,  7, 1, 0, 0, FULL_VAL, 4};
        v[7]  = '{16'h2000, 1'b0, 16'h0009, 2,  8, 1, 0, 0, FULL_VAL, 4};
        v[8]  = '{K_BS,     1'b0, 16'h0000, 1,  9, 0, 0, 0, FULL_VAL, 4};
        v[9]  = '{K_BS,     1'b0, 16'h0000, 0, 10, 0, 0, 0, FULL_VAL, 4};
        v[10] = '{K_BS,     1'b0, 16'h0000, 0, 11, 0, 0, 0, FULL_VAL, 4};
        v[11] = '{K_ENT,    1'b0, 16'h0000, 0, 12, 0, 0, 1, 16'h0000, 0};
        v[12] = '{16'h1000, 1'b0, 16'h0000, 0, 12, 0, 0, 0, 16'h0000, 0};
        v[13] = '{16'h00A0, 1'b0, 16'h0000, 0, 12, 0, 0, 0, 16'h0000, 0};
        v[14] = '{16'h0020, 1'b1, 16'h0000, 0, 13, 0, 0, 0, 16'h0000, 0};
        v[15] = '{16'h0080, 1'b0, 16'h0001, 1, 14, 1, 0, 0, 16'h0000, 0};
        v[16] = '{16'h0040, 1'b0, 16'h0012, 2, 15, 1, 0, 0, 16'h0000, 0};
        v[17] = '{16'h0020, 1'b0, 16'h0123, 3, 16, 1, 0, 0, 16'h0000, 0};
        v[18] = '{K_BS,     1'b0, 16'h0012, 2, 17, 0, 0, 0, 16'h0000, 0};
        v[19] = '{K_ENT,    1'b0, 16'h0000, 0, 18, 0, 0, 1, 16'h0012, 2};

        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // first press: pulse on the 6th edge after the change
        onehot = 16'h0080;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            chk($sformatf("latency_dv_edge%0d", e), digit_valid, e == 6);
        end
        chk("latency_digits", 32'(digits), 32'h0001);
        chk("latency_count", 32'(count), 1);
        chk("latency_press", 32'(press_cnt), 1);
        onehot = '0;
        tick(8);

        // bouncing key never holds D samples, then settles
        b_dv = n_dv;
        repeat (5) begin
            onehot = 16'h0080; tick(2);
            onehot = 16'h0000; tick(1);
        end
        chk("glitch_no_event", n_dv - b_dv, 0);
        chk("glitch_press", 32'(press_cnt), 1);
        onehot = 16'h0080; tick(8);
        onehot = 16'h0000; tick(8);
        chk("glitch_one_event", n_dv - b_dv, 1);
        chk("glitch_digits", 32'(digits), 32'h0011);

        // async reset while ARMED, key still held afterwards
        onehot = 16'h0040;
        tick(2);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        tick(1);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            chk($sformatf("rearm_dv_edge%0d", e), digit_valid, e == 6);
        end
        chk("rearm_digits", 32'(digits), 32'h0002);
        chk("rearm_press", 32'(press_cnt), 1);
        onehot = '0;
        tick(8);

        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        foreach (v[r]) begin
            b_dv = n_dv; b_ov = n_ov; b_ev = n_ev;
            onehot = v[r].key; clear = v[r].clr;
            tick(8);
            onehot = '0; clear = 1'b0;
            tick(8);
            chk($sformatf("row%0d_digits", r), 32'(digits), 32'(v[r].dig));
            chk($sformatf("row%0d_count", r), 32'(count), v[r].cnt);
            chk($sformatf("row%0d_full", r), full, v[r].cnt == N);
            chk($sformatf("row%0d_press", r), 32'(press_cnt), v[r].press);
            chk($sformatf("row%0d_dv", r), n_dv - b_dv, v[r].dv);
            chk($sformatf("row%0d_ov", r), n_ov - b_ov, v[r].ov);
            chk($sformatf("row%0d_ev", r), n_ev - b_ev, v[r].ev);
            chk($sformatf("row%0d_eval", r), 32'(entry_value), 32'(v[r].eval));
            chk($sformatf("row%0d_elen", r), 32'(entry_len), v[r].elen);
        end

        for (int i = 0; i < 700; i++) begin
            onehot = pool[$urandom_range(0, 17)];
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                clear = ($urandom_range(0, 24) == 0);
                tick(1);
            end
        end
        clear = 1'b0; onehot = '0;
        tick(10);

        // press counter saturates rather than wrapping
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        for (int i = 0; i < 260; i++) begin
            onehot = K_ENT; tick(5);
            onehot = '0;    tick(6);
            if (i == 253) chk("sat_press_254", 32'(press_cnt), 254);
        end
        chk("sat_press_final", 32'(press_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
